// File: rtl/demux_pkg.sv
// Shared types and the circular channel scan used by the stream scheduler.
package demux_pkg;

    localparam int NCH = 4;

    typedef logic [1:0] ch_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // First enabled channel after `from` (from+1, from+2, from+3); `from` itself if none.
    function automatic ch_t next_en(input ch_t from, input logic [NCH-1:0] mask);
        ch_t c;
        next_en = from;
        for (int i = NCH - 1; i >= 1; i--) begin
            c = from + ch_t'(i);
            if (mask[c]) next_en = c;
        end
    endfunction

endpackage

// File: rtl/demux_rr_pick.sv
// Rotate-priority picker: target channel for the next word and the channel after it.
module demux_rr_pick
    import demux_pkg::*;
(
    input  ch_t            ptr,
    input  logic [NCH-1:0] en_mask,
    output ch_t            tgt,
    output ch_t            nxt,
    output logic           any_en,
    output logic           ptr_hit
);

    assign ptr_hit = en_mask[ptr];
    assign tgt     = ptr_hit ? ptr : next_en(ptr, en_mask);
    assign nxt     = next_en(tgt, en_mask);
    assign any_en  = |en_mask;

endmodule

// File: rtl/demux_stream_sched.sv
// One-word output register feeding the 4-way demux, channels chosen round-robin in bursts.
module demux_stream_sched
    import demux_pkg::*;
#(
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] en_mask,
    input  logic           in_valid,
    input  logic [DW-1:0]  in_data,
    output logic           in_ready,
    output logic [NCH-1:0] out_valid,
    output logic [DW-1:0]  out_data,
    input  logic [NCH-1:0] out_ready,
    output logic [1:0]     sel,
    output logic           burst_done
);

    localparam int            BW        = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST - 1);

    state_t         state, state_nxt;
    logic [DW-1:0]  data_q;
    ch_t            ch_q, ptr, tgt, nxt;
    logic           last_q;
    logic [BW-1:0]  beat, eff_beat;
    logic           any_en, ptr_hit, full, acc, dlv, is_last;

    demux_rr_pick u_pick (
        .ptr     (ptr),
        .en_mask (en_mask),
        .tgt     (tgt),
        .nxt     (nxt),
        .any_en  (any_en),
        .ptr_hit (ptr_hit)
    );

    assign full     = (state == FULL);
    assign dlv      = full & out_ready[ch_q];
    assign in_ready = rst_n & any_en & (!full | out_ready[ch_q]);
    assign acc      = in_valid & in_ready;

    // A skipped pointer channel starts a fresh burst on the substitute.
    assign eff_beat = ptr_hit ? beat : '0;
    assign is_last  = (eff_beat == BEAT_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (acc) state_nxt = FULL;
            FULL:    if (dlv && !acc) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q     <= '0;
            ch_q       <= '0;
            last_q     <= 1'b0;
            ptr        <= '0;
            beat       <= '0;
            burst_done <= 1'b0;
        end else begin
            burst_done <= dlv & last_q;
            if (acc) begin
                data_q <= in_data;
                ch_q   <= tgt;
                last_q <= is_last;
                if (is_last) begin
                    beat <= '0;
                    ptr  <= nxt;
                end else begin
                    beat <= eff_beat + 1'b1;
                    ptr  <= tgt;
                end
            end
        end
    end

    always_comb begin
        out_valid = '0;
        if (full) out_valid[ch_q] = 1'b1;
    end

    assign out_data = data_q;
    assign sel      = ch_q;

endmodule

// File: tb/tb_demux_stream_sched.sv
// Directed bench for demux_stream_sched: bursts, skipping, backpressure, mask changes, reset.
module tb_demux_stream_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] en_mask, out_ready, out_valid;
    logic       in_valid, in_ready, burst_done;
    logic [7:0] in_data, out_data;
    logic [1:0] sel;
    int         total = 0;
    int         bad = 0;

    demux_stream_sched #(.DW(8), .BURST(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_mask    (en_mask),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .sel        (sel),
        .burst_done (burst_done)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
        en_mask = 4'b1111; out_ready = 4'b1111;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        en_mask = 4'b1111; out_ready = 4'b1111; in_valid = 1'b1; in_data = 8'h3C;
        #1 rst_n = 1'b0;
        #2;
        total++;
        if (out_valid !== 4'b0000 || out_data !== 8'h00 || sel !== 2'b00 ||
            burst_done !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got v=%b d=%h s=%b bd=%b rdy=%b want v=0000 d=00 s=00 bd=0 rdy=0",
                     out_valid, out_data, sel, burst_done, in_ready);
        end
        in_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_release_ready got=%b want=1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        logic [3:0] ev;
        logic       eb;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            in_valid = (i < 16); in_data = 8'(i);
            @(negedge clk);
            if (i < 16) begin
                total++;
                if (in_ready !== 1'b1) begin
                    bad++; $display("FAIL rr_ready[%0d] got=%b want=1", i, in_ready);
                end
            end
            ev = (i >= 1 && i <= 16) ? (4'b0001 << ((i - 1) / 4)) : 4'b0000;
            total++;
            if (out_valid !== ev || (i >= 1 && i <= 16 &&
                (out_data !== 8'(i - 1) || sel !== 2'((i - 1) / 4)))) begin
                bad++;
                $display("FAIL rr_out[%0d] got v=%b d=%h s=%0d want v=%b d=%h s=%0d",
                         i, out_valid, out_data, sel, ev, 8'(i - 1), (i - 1) / 4);
            end
            if (i >= 2) begin
                eb = ((i - 2) % 4 == 3);
                total++;
                if (burst_done !== eb) begin
                    bad++; $display("FAIL rr_burst_done[%0d] got=%b want=%b", i, burst_done, eb);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_skip();
        logic [3:0] ev;
        logic       eb;
        int         c;
        do_reset();
        en_mask = 4'b0101;
        for (int i = 0; i < 10; i++) begin
            in_valid = (i < 8); in_data = 8'(8'h40 + i);
            @(negedge clk);
            if (i >= 1 && i <= 8) begin
                c  = (i - 1 < 4) ? 0 : 2;
                ev = 4'b0001 << c;
                total++;
                if (out_valid !== ev || out_data !== 8'(8'h40 + i - 1) || sel !== 2'(c)) begin
                    bad++;
                    $display("FAIL skip_out[%0d] got v=%b d=%h s=%0d want v=%b d=%h s=%0d",
                             i, out_valid, out_data, sel, ev, 8'(8'h40 + i - 1), c);
                end
            end
            if (i >= 2) begin
                eb = (i - 2 == 3) || (i - 2 == 7);
                total++;
                if (burst_done !== eb) begin
                    bad++; $display("FAIL skip_burst_done[%0d] got=%b want=%b", i, burst_done, eb);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 4'b1110; in_valid = 1'b1; in_data = 8'hA5;
        @(posedge clk); #1;
        in_data = 8'h5A;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (in_ready !== 1'b0 || out_data !== 8'hA5 || out_valid !== 4'b0001) begin
                bad++;
                $display("FAIL bp_hold[%0d] got rdy=%b d=%h v=%b want rdy=0 d=a5 v=0001",
                         i, in_ready, out_data, out_valid);
            end
            @(posedge clk); #1;
        end
        out_ready = 4'b1111;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release_ready got=%b want=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (out_data !== 8'h5A || out_valid !== 4'b0001 || burst_done !== 1'b0) begin
            bad++;
            $display("FAIL bp_reload got d=%h v=%b bd=%b want d=5a v=0001 bd=0",
                     out_data, out_valid, burst_done);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (out_valid !== 4'b0000) begin
            bad++; $display("FAIL bp_drain got v=%b want v=0000", out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mask_change();
        logic [3:0] ev;
        logic       eb;
        int         c;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            in_valid = (i < 10); in_data = 8'(8'h80 + i);
            if (i >= 6) en_mask = 4'b1101;
            @(negedge clk);
            if (i >= 1 && i <= 10) begin
                c  = (i - 1 < 4) ? 0 : ((i - 1 < 6) ? 1 : 2);
                ev = 4'b0001 << c;
                total++;
                if (out_valid !== ev || out_data !== 8'(8'h80 + i - 1) || sel !== 2'(c)) begin
                    bad++;
                    $display("FAIL mask_out[%0d] got v=%b d=%h s=%0d want v=%b d=%h s=%0d",
                             i, out_valid, out_data, sel, ev, 8'(8'h80 + i - 1), c);
                end
            end
            if (i >= 2) begin
                eb = (i - 2 == 3) || (i - 2 == 9);
                total++;
                if (burst_done !== eb) begin
                    bad++; $display("FAIL mask_burst_done[%0d] got=%b want=%b", i, burst_done, eb);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_all_disabled();
        do_reset();
        out_ready = 4'b0000; in_valid = 1'b1; in_data = 8'h77;
        @(posedge clk); #1;
        in_data = 8'h88; en_mask = 4'b0000;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0 || out_valid !== 4'b0001 || out_data !== 8'h77) begin
            bad++;
            $display("FAIL off_held got rdy=%b v=%b d=%h want rdy=0 v=0001 d=77",
                     in_ready, out_valid, out_data);
        end
        @(posedge clk); #1;
        out_ready = 4'b1111;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0 || out_valid !== 4'b0001) begin
            bad++;
            $display("FAIL off_drain got rdy=%b v=%b want rdy=0 v=0001", in_ready, out_valid);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 4'b0000 || in_ready !== 1'b0 || out_data !== 8'h77) begin
                bad++;
                $display("FAIL off_idle[%0d] got v=%b rdy=%b d=%h want v=0000 rdy=0 d=77",
                         i, out_valid, in_ready, out_data);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_data = 8'(k);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 4'b0000;
        @(negedge clk);
        total++;
        if (out_valid !== 4'b0100 || sel !== 2'd2 || out_data !== 8'h09) begin
            bad++;
            $display("FAIL rst_mid_pre got v=%b s=%0d d=%h want v=0100 s=2 d=09",
                     out_valid, sel, out_data);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 4'b0000 || sel !== 2'b00 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_async got v=%b s=%b rdy=%b want v=0000 s=00 rdy=0",
                     out_valid, sel, in_ready);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        out_ready = 4'b1111; in_valid = 1'b1; in_data = 8'h55;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL rst_mid_ready got=%b want=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 4'b0001 || sel !== 2'b00 || out_data !== 8'h55) begin
            bad++;
            $display("FAIL rst_mid_first got v=%b s=%b d=%h want v=0001 s=00 d=55",
                     out_valid, sel, out_data);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        in_valid = 1'b0; in_data = '0; en_mask = 4'b1111; out_ready = 4'b1111;
        test_reset();
        test_round_robin();
        test_skip();
        test_backpressure();
        test_mask_change();
        test_all_disabled();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
